// File: rtl/traffic_pkg.sv
// traffic_pkg: LED encodings shared by both road controllers and the country-road FSM states
package traffic_pkg;
  localparam logic [2:0] LED_RED = 3'b100;
  localparam logic [2:0] LED_YELLOW = 3'b010;
  localparam logic [2:0] LED_GREEN = 3'b001;
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GREEN,
    YELLOW,
    DONE,
    HOLD
  } cr_state_e;
  function automatic logic [2:0] cr_led(input cr_state_e s);
    return s == GREEN ? LED_GREEN : s == YELLOW ? LED_YELLOW : LED_RED;
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter; done is high once the loaded count has run out
module phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  assign done = cnt_q == '0;
  always_comb cnt_d = load ? load_val : done ? cnt_q : cnt_q - ONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/countryroad.sv
// countryroad: country-road light sequencer; runs clear/green/yellow on enable and
// returns right-of-way to the highway with a one-cycle timeout pulse.
module countryroad
  import traffic_pkg::*;
#(
  parameter int ALLRED_CYCLES = 2,
  parameter int GREEN_MIN     = 5,
  parameter int GREEN_MAX     = 10,
  parameter int YELLOW_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_countryroad,
  input  logic       sensor,
  output logic       timeout,
  output logic [2:0] countryroad_led
);
  localparam int LONG_AG = GREEN_MAX > ALLRED_CYCLES ? GREEN_MAX : ALLRED_CYCLES;
  localparam int LONGEST = LONG_AG > YELLOW_CYCLES ? LONG_AG : YELLOW_CYCLES;
  localparam int W = $clog2(LONGEST + 1);
  localparam logic [W-1:0] CLR_V = W'(ALLRED_CYCLES - 1);
  localparam logic [W-1:0] MIN_V = W'(GREEN_MIN - 1);
  localparam logic [W-1:0] EXT_V = W'(GREEN_MAX > GREEN_MIN ? GREEN_MAX - GREEN_MIN - 1 : 0);
  localparam logic [W-1:0] YEL_V = W'(YELLOW_CYCLES - 1);
  localparam logic NO_EXT = GREEN_MAX == GREEN_MIN;
  cr_state_e state_q, state_d;
  logic ext_q, ext_d, to_yellow, extend, load, done;
  logic [W-1:0] load_val;
  logic [2:0] led_q;
  logic timeout_q;
  phase_timer #(.WIDTH(W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .done    (done)
  );
  // Green runs as a GREEN_MIN window, then an optional sensor-driven extension reloaded up to GREEN_MAX.
  always_comb begin
    to_yellow = !enable_countryroad || (!sensor && (done || ext_q)) || (done && (ext_q || NO_EXT));
    extend = state_q == GREEN && done && !ext_q && !to_yellow;
    case (state_q)
      IDLE:    state_d = enable_countryroad ? CLEAR : IDLE;
      CLEAR:   state_d = !enable_countryroad ? IDLE : done ? GREEN : CLEAR;
      GREEN:   state_d = to_yellow ? YELLOW : GREEN;
      YELLOW:  state_d = done ? DONE : YELLOW;
      DONE:    state_d = HOLD;
      HOLD:    state_d = enable_countryroad ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
    ext_d = state_q == GREEN && state_d == GREEN && (ext_q || extend);
    load = state_d != state_q || extend;
    load_val = extend ? EXT_V : state_d == CLEAR ? CLR_V : state_d == GREEN ? MIN_V
             : state_d == YELLOW ? YEL_V : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ext_q     <= 1'b0;
      led_q     <= LED_RED;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ext_q     <= ext_d;
      led_q     <= cr_led(state_d);
      timeout_q <= state_d == DONE;
    end
  end
  assign countryroad_led = led_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_countryroad.sv
// tb_countryroad: scenario tasks checked cycle by cycle against an elapsed-time reference model
module tb_countryroad;
  localparam int ALLRED = 2, GMIN = 5, GMAX = 10, YEL = 3;
  logic clk = 1'b0, rst_n = 1'b0, enable_countryroad = 1'b0, sensor = 1'b0;
  logic timeout;
  logic [2:0] countryroad_led;
  int checks = 0, errors = 0;
  int m_ph = 0, m_t = 0;
  int cyc, green_at, yellow_at, to_at, to_cnt;
  logic [2:0] e_led;
  logic e_to;

  countryroad dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable_countryroad(enable_countryroad),
    .sensor            (sensor),
    .timeout           (timeout),
    .countryroad_led   (countryroad_led)
  );

  always #5 clk = ~clk;

  // Phases: 0 idle, 1 clear, 2 green, 3 yellow, 4 done, 5 hold; m_t counts cycles spent in phase.
  always_comb begin
    e_led = m_ph == 2 ? 3'b001 : m_ph == 3 ? 3'b010 : 3'b100;
    e_to = m_ph == 4;
  end

  task automatic model(input logic en, input logic sen);
    case (m_ph)
      0: if (en) begin m_ph = 1; m_t = 0; end
      1: begin
        m_t++;
        if (!en) m_ph = 0;
        else if (m_t == ALLRED) begin m_ph = 2; m_t = 0; end
      end
      2: begin
        m_t++;
        if (!en || (m_t >= GMIN && !sen) || m_t == GMAX) begin m_ph = 3; m_t = 0; end
      end
      3: begin m_t++; if (m_t == YEL) m_ph = 4; end
      4: m_ph = 5;
      default: if (!en) m_ph = 0;
    endcase
  endtask

  task automatic mark();
    cyc = 0; green_at = -1; yellow_at = -1; to_at = -1; to_cnt = 0;
  endtask

  task automatic step(input logic en, input logic sen);
    enable_countryroad = en;
    sensor = sen;
    @(posedge clk);
    model(en, sen);
    #1;
    if (countryroad_led == 3'b001 && green_at < 0) green_at = cyc;
    if (countryroad_led == 3'b010 && yellow_at < 0) yellow_at = cyc;
    if (timeout) begin
      if (to_at < 0) to_at = cyc;
      to_cnt++;
    end
    cyc++;
  endtask

  task automatic idle_out();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (countryroad_led !== 3'b100 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: led=%b timeout=%b, expected led=100 timeout=0", countryroad_led, timeout);
    end
    rst_n = 1'b1;
    m_ph = 0;
    mark();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, $urandom_range(0, 1) == 1);
      checks++;
      if (countryroad_led !== 3'b100 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc %0d: led=%b timeout=%b, expected led=100 timeout=0", i, countryroad_led, timeout);
      end
    end
  endtask

  task automatic test_min_green();
    mark();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (countryroad_led !== e_led || timeout !== e_to) begin
        errors++;
        $display("FAIL min_green cyc %0d: led=%b timeout=%b, expected led=%b timeout=%b", i, countryroad_led, timeout, e_led, e_to);
      end
    end
    checks++;
    if (green_at != 2 || yellow_at != 7 || to_at != 10 || to_cnt != 1) begin
      errors++;
      $display("FAIL min_green timing: green=%0d yellow=%0d timeout=%0d x%0d, expected 2 7 10 x1", green_at, yellow_at, to_at, to_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (countryroad_led !== 3'b100 || timeout !== 1'b0 || m_ph != 0) begin
        errors++;
        $display("FAIL min_green release cyc %0d: led=%b timeout=%b, expected led=100 timeout=0", i, countryroad_led, timeout);
      end
    end
  endtask

  task automatic test_max_green();
    mark();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (countryroad_led !== e_led || timeout !== e_to) begin
        errors++;
        $display("FAIL max_green cyc %0d: led=%b timeout=%b, expected led=%b timeout=%b", i, countryroad_led, timeout, e_led, e_to);
      end
    end
    checks++;
    if (green_at != 2 || yellow_at != 12 || to_at != 15 || to_cnt != 1) begin
      errors++;
      $display("FAIL max_green timing: green=%0d yellow=%0d timeout=%0d x%0d, expected 2 12 15 x1", green_at, yellow_at, to_at, to_cnt);
    end
    idle_out();
  endtask

  task automatic test_sensor_ext();
    mark();
    for (int i = 0; i < 18; i++) begin
      step(1'b1, i < 9);
      checks++;
      if (countryroad_led !== e_led || timeout !== e_to) begin
        errors++;
        $display("FAIL sensor_ext cyc %0d: led=%b timeout=%b, expected led=%b timeout=%b", i, countryroad_led, timeout, e_led, e_to);
      end
    end
    checks++;
    if (green_at != 2 || yellow_at != 9 || to_at != 12 || to_cnt != 1) begin
      errors++;
      $display("FAIL sensor_ext timing: green=%0d yellow=%0d timeout=%0d x%0d, expected 2 9 12 x1", green_at, yellow_at, to_at, to_cnt);
    end
    idle_out();
  endtask

  task automatic test_abort_green();
    mark();
    for (int i = 0; i < 14; i++) begin
      step(i < 4, 1'b1);
      checks++;
      if (countryroad_led !== e_led || timeout !== e_to) begin
        errors++;
        $display("FAIL abort_green cyc %0d: led=%b timeout=%b, expected led=%b timeout=%b", i, countryroad_led, timeout, e_led, e_to);
      end
    end
    checks++;
    if (green_at != 2 || yellow_at != 4 || to_at != 7 || to_cnt != 1) begin
      errors++;
      $display("FAIL abort_green timing: green=%0d yellow=%0d timeout=%0d x%0d, expected 2 4 7 x1", green_at, yellow_at, to_at, to_cnt);
    end
  endtask

  task automatic test_abort_clear();
    mark();
    for (int i = 0; i < 12; i++) begin
      step(i == 0, $urandom_range(0, 1) == 1);
      checks++;
      if (countryroad_led !== e_led || timeout !== e_to) begin
        errors++;
        $display("FAIL abort_clear cyc %0d: led=%b timeout=%b, expected led=%b timeout=%b", i, countryroad_led, timeout, e_led, e_to);
      end
    end
    checks++;
    if (green_at != -1 || to_cnt != 0) begin
      errors++;
      $display("FAIL abort_clear outcome: green=%0d pulses=%0d, expected -1 0", green_at, to_cnt);
    end
  endtask

  task automatic test_async_reset();
    mark();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    checks++;
    if (countryroad_led !== 3'b010) begin
      errors++;
      $display("FAIL async_yellow precondition: led=%b, expected led=010", countryroad_led);
    end
    #2 rst_n = 1'b0;
    #1;
    m_ph = 0;
    checks++;
    if (countryroad_led !== 3'b100 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL async_yellow: led=%b timeout=%b, expected led=100 timeout=0", countryroad_led, timeout);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    mark();
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
    checks++;
    if (timeout !== 1'b1 || to_at != 10) begin
      errors++;
      $display("FAIL async_done precondition: timeout=%b at %0d, expected 1 at 10", timeout, to_at);
    end
    #2 rst_n = 1'b0;
    #1;
    m_ph = 0;
    checks++;
    if (countryroad_led !== 3'b100 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL async_done: led=%b timeout=%b, expected led=100 timeout=0", countryroad_led, timeout);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    mark();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (countryroad_led !== e_led || timeout !== e_to) begin
        errors++;
        $display("FAIL async_rerun cyc %0d: led=%b timeout=%b, expected led=%b timeout=%b", i, countryroad_led, timeout, e_led, e_to);
      end
    end
    checks++;
    if (green_at != 2 || yellow_at != 7 || to_at != 10 || to_cnt != 1) begin
      errors++;
      $display("FAIL async_rerun timing: green=%0d yellow=%0d timeout=%0d x%0d, expected 2 7 10 x1", green_at, yellow_at, to_at, to_cnt);
    end
    idle_out();
  endtask

  task automatic test_random();
    logic en = 1'b0, sen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) en = ~en;
      if ($urandom_range(0, 3) == 0) sen = ~sen;
      step(en, sen);
      checks++;
      if (countryroad_led !== e_led || timeout !== e_to) begin
        errors++;
        $display("FAIL random cyc %0d: led=%b timeout=%b, expected led=%b timeout=%b", i, countryroad_led, timeout, e_led, e_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_min_green();
    test_max_green();
    test_sensor_ext();
    test_abort_green();
    test_abort_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/countryroad.md
# countryroad

Country-road side of the highway/country-road traffic-light pair. It consumes `enable_countryroad` from the highway controller and runs the country-road light through clearance, green, and yellow phases. When the phase ends it hands right-of-way back with a one-cycle `timeout` pulse, which drives the highway controller's `timeout` input. The country-road vehicle `sensor` is shared with the highway controller and extends the country green.

## Interface
- `ALLRED_CYCLES`, 2: all-red clearance length before country green; must be ≥1
- `GREEN_MIN`, 5: minimum country green length; must be ≥1
- `GREEN_MAX`, 10: maximum country green length; must be ≥ `GREEN_MIN`
- `YELLOW_CYCLES`, 3: country yellow length; must be ≥1
- `clk` input 1: single clock, all state changes on the rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `enable_countryroad` input 1: level from the highway controller; high means the highway is red and the country road may proceed
- `sensor` input 1: level; high means a vehicle is waiting on or occupying the country road
- `timeout` output 1: registered; one-cycle pulse returning right-of-way to the highway
- `countryroad_led` output 3: registered, one-hot; [2]=red, [1]=yellow, [0]=green

## Operation
- States:
  - `IDLE`: red; waiting for enable.
  - `CLEAR`: red; all-red clearance.
  - `GREEN`: green.
  - `YELLOW`: yellow.
  - `DONE`: red; `timeout`=1.
  - `HOLD`: red; waiting for enable to drop.
- Transitions:
  - `IDLE` → `CLEAR` when `enable_countryroad`=1 is sampled.
  - `CLEAR` → `GREEN` after `ALLRED_CYCLES` cycles.
  - `GREEN` → `YELLOW` on the first of these:
    - elapsed ≥ `GREEN_MIN` and `sensor`=0;
    - elapsed = `GREEN_MAX`;
    - `enable_countryroad`=0 (abort, any time).
  - `YELLOW` → `DONE` after `YELLOW_CYCLES` cycles. A dropped enable does not shorten yellow.
  - `DONE` → `HOLD`, always after one cycle.
  - `HOLD` → `IDLE` when `enable_countryroad`=0.
- An enable that drops during `CLEAR` returns the block to `IDLE` directly, with no `timeout` pulse.
- `timeout` is high only in `DONE`. Holding enable high never retriggers the sequence until enable has dropped in `HOLD`.
- Phase counter:
  - Width is `$clog2(GREEN_MAX+1)`, or wider if `ALLRED_CYCLES` or `YELLOW_CYCLES` exceeds `GREEN_MAX`.
  - Unsigned; reloads on every state entry.
  - Never wraps; saturation is unreachable by construction.
- LED output is a pure function of the registered state. Exactly one bit is set at all times after reset.

## Timing
- Reset values: state `IDLE`, `countryroad_led`=3'b100, `timeout`=0, counter 0.
- Reset is asynchronous, immediate, from any state, including mid-green or mid-pulse. Any `timeout` pulse in progress is cut.
- The first rising edge with `rst_n`=1 samples inputs normally.
- Let enable first be sampled high at edge N. Registered outputs then change as follows:
  - `CLEAR` visible after edge N.
  - green after edge N+`ALLRED_CYCLES`.
  - yellow after edge N+`ALLRED_CYCLES`+G, where G is the green length.
  - `timeout` high for exactly one cycle after edge N+`ALLRED_CYCLES`+G+`YELLOW_CYCLES`.
- Green length G:
  - G=`GREEN_MIN` if `sensor`=0 at the `GREEN_MIN` boundary.
  - Otherwise, G is the first cycle in (`GREEN_MIN`, `GREEN_MAX`] where `sensor`=0 is sampled, capped at `GREEN_MAX`.
- `sensor` and enable are sampled on the same edge. If both change on that edge, the abort (enable=0) wins.
- No combinational path from any input to any output.

## Structure
- Shared package `traffic_pkg` holds:
  - the LED one-hot constants `LED_RED`, `LED_YELLOW`, `LED_GREEN` (used by both highway and countryroad);
  - the `countryroad` state enum.
- One sub-module, `phase_timer`:
  - loadable down-counter with a `done` flag;
  - parameter `WIDTH`;
  - ports `clk`, `rst_n`, `load`, `load_val`, `done`.
- The parent FSM decides the loads and the sensor extension.

## Test plan
All scenarios use default parameters; N is the edge at which enable is sampled high.
- Reset then idle: `rst_n` pulsed low for 2 cycles, enable=0 for 20 cycles → LED=3'b100 and `timeout`=0 throughout.
- Minimum green: enable rises with `sensor`=0 → LED red N..N+1, green N+2..N+6, yellow N+7..N+9. `timeout`=1 only in cycle N+10. LED stays red while enable=1, then `IDLE` after enable drops.
- Maximum green: `sensor` held 1 → green N+2..N+11, yellow N+12..N+14, `timeout` at N+15.
- Sensor extension: `sensor`=1 then dropped to 0 at green cycle 7 → yellow begins exactly 7 cycles after green start, `timeout` 3 cycles later.
- Aborts:
  - Enable dropped at green cycle 2 → yellow next cycle, full 3-cycle yellow, then `timeout` pulse.
  - Enable dropped during `CLEAR` → `IDLE`, no pulse.
- Async reset: `rst_n` low mid-yellow and mid-`DONE` → LED=3'b100 and `timeout`=0 immediately, without waiting for a clock edge. A fresh enable afterwards reproduces the minimum-green timing.
